// File: rtl/ppf_pkg.sv
`default_nettype none
// ppf_pkg: shared sizing, state encoding and lane helpers for the polyphase front-end scheduler.
package ppf_pkg;

  localparam int NUM_CH = 8;
  localparam int DW     = 32;
  localparam int TAPS   = 4;

  localparam int CNT_W = $clog2(NUM_CH);
  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int BLK_W = NUM_CH * DW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  function automatic int lane_lsb(input int k);
    return k * DW;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppf_lat_track.sv
`default_nettype none
// ppf_lat_track: fixed-latency valid pipe behind the filter bank plus a wrapping spectrum counter.
module ppf_lat_track #(
  parameter int PIPE_LAT = 6,
  parameter int FCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              blk_valid,
  output logic              spec_valid,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              pipe_busy
);

  logic [PIPE_LAT-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe      <= '0;
      frame_cnt <= '0;
    end else begin
      pipe <= (pipe << 1) | PIPE_LAT'(blk_valid);
      if (pipe[PIPE_LAT-1]) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign spec_valid = pipe[PIPE_LAT-1];
  assign pipe_busy  = |pipe;

endmodule
`default_nettype wire

// File: rtl/ppf_sched.sv
`default_nettype none
// ppf_sched: commutates a serial complex stream into NUM_CH-lane blocks, strobes the filter bank
// and drains its taps with zero blocks on flush.
module ppf_sched
  import ppf_pkg::*;
#(
  parameter int PIPE_LAT = 6,
  parameter int FCNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic              s_valid_i,
  input  logic [DW-1:0]     s_data_i,
  output logic              s_ready_o,
  output logic [BLK_W-1:0]  blk_data_o,
  output logic              blk_valid_o,
  output logic              spec_valid_o,
  output logic [FCNT_W-1:0] frame_cnt_o,
  output logic              busy_o
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TAP_W-1:0] fcnt;
  logic             flush_pend;
  logic [DW-1:0]    shadow [NUM_CH];
  logic [BLK_W-1:0] blk_data;
  logic             blk_valid;
  logic             s_ready;
  logic             hs;
  logic             blk_done;
  logic             pipe_busy;
  logic [BLK_W-1:0] full_blk;

  assign hs       = s_valid_i & s_ready;
  assign blk_done = hs && (cnt == CNT_W'(NUM_CH - 1));

  // The final sample of a block lands in lane 0 straight from the input, so the
  // strobe follows the last handshake by a single cycle.
  always_comb begin
    full_blk = '0;
    for (int k = 1; k < NUM_CH; k++) begin
      full_blk[lane_lsb(k) +: DW] = shadow[k];
    end
    full_blk[DW-1:0] = s_data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      cnt        <= '0;
      fcnt       <= '0;
      flush_pend <= 1'b0;
      blk_data   <= '0;
      blk_valid  <= 1'b0;
      s_ready    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        shadow[k] <= '0;
      end
    end else begin
      blk_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_i) begin
            state <= FLUSH;
            fcnt  <= '0;
          end else if (enable_i) begin
            state   <= COLLECT;
            s_ready <= 1'b1;
          end
        end

        COLLECT: begin
          if (flush_i) begin
            flush_pend <= 1'b1;
          end
          if (hs) begin
            shadow[CNT_W'(NUM_CH - 1) - cnt] <= s_data_i;
            cnt                              <= cnt + 1'b1;
          end
          if (blk_done) begin
            blk_data  <= full_blk;
            blk_valid <= 1'b1;
          end
          // Mode changes only happen on a block boundary; a pending flush beats a disable.
          if (blk_done || (cnt == '0 && !hs)) begin
            if (flush_pend || flush_i) begin
              state      <= FLUSH;
              fcnt       <= '0;
              flush_pend <= 1'b0;
              s_ready    <= 1'b0;
            end else if (!enable_i) begin
              state   <= IDLE;
              s_ready <= 1'b0;
            end
          end
        end

        FLUSH: begin
          blk_data  <= '0;
          blk_valid <= 1'b1;
          fcnt      <= fcnt + 1'b1;
          if (fcnt == TAP_W'(TAPS - 1)) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end

        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
        end
      endcase
    end
  end

  ppf_lat_track #(
    .PIPE_LAT (PIPE_LAT),
    .FCNT_W   (FCNT_W)
  ) u_lat (
    .clk        (clk_i),
    .rst_n      (rstn_i),
    .blk_valid  (blk_valid),
    .spec_valid (spec_valid_o),
    .frame_cnt  (frame_cnt_o),
    .pipe_busy  (pipe_busy)
  );

  assign s_ready_o   = s_ready;
  assign blk_data_o  = blk_data;
  assign blk_valid_o = blk_valid;
  assign busy_o      = (state != IDLE) | pipe_busy;

endmodule
`default_nettype wire

// File: tb/tb_ppf_sched.sv
`default_nettype none
// tb_ppf_sched: directed scenarios with a block/spectrum scoreboard for ppf_sched.
module tb_ppf_sched;
  import ppf_pkg::*;

  localparam int PL = 6;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic             s_ready_o;
  logic [BLK_W-1:0] blk_data_o;
  logic             blk_valid_o;
  logic             spec_valid_o;
  logic [FW-1:0]    frame_cnt_o;
  logic             busy_o;

  ppf_sched #(.PIPE_LAT(PL), .FCNT_W(FW)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .enable_i     (enable),
    .flush_i      (flush),
    .s_valid_i    (s_valid),
    .s_data_i     (s_data),
    .s_ready_o    (s_ready_o),
    .blk_data_o   (blk_data_o),
    .blk_valid_o  (blk_valid_o),
    .spec_valid_o (spec_valid_o),
    .frame_cnt_o  (frame_cnt_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int spec_cnt = 0;
  int last_spec = -1;
  int blk_seen = 0;
  int mcnt = 0;
  logic [BLK_W-1:0] mblk = '0;
  logic [BLK_W-1:0] exp_q[$];
  int spec_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe pops an expected block and schedules its spectrum time.
  always @(negedge clk) begin
    if (rstn) begin
      if (blk_valid_o) begin
        blk_seen++;
        if (exp_q.size() == 0) check("blk_unexpected", BLK_W'(blk_valid_o), BLK_W'(0));
        else check("blk_data", blk_data_o, exp_q.pop_front());
        spec_q.push_back(cyc + PL);
      end
      if (spec_valid_o) begin
        spec_cnt++;
        last_spec = cyc;
        if (spec_q.size() == 0) check("spec_unexpected", BLK_W'(spec_valid_o), BLK_W'(0));
        else check("spec_time", BLK_W'(cyc), BLK_W'(spec_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    rstn = 1'b0; enable = 1'b0; flush = 1'b0; s_valid = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete(); spec_q.delete();
    mcnt = 0; mblk = '0; spec_cnt = 0; last_spec = -1;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int g = 0;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    while (!s_ready_o && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (!s_ready_o) begin
      check("ready_timeout", BLK_W'(s_ready_o), BLK_W'(1));
      s_valid = 1'b0;
      return;
    end
    mblk[(NUM_CH - 1 - mcnt) * DW +: DW] = d;
    mcnt++;
    if (mcnt == NUM_CH) begin
      exp_q.push_back(mblk);
      mcnt = 0;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic push_zeros();
    for (int i = 0; i < TAPS; i++) exp_q.push_back('0);
  endtask

  initial begin
    #2_000_000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "FAIL watchdog");
  end

  initial begin
    int g;
    int b0;
    int seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", BLK_W'(s_ready_o), BLK_W'(0));
    check("rst_blk_valid", BLK_W'(blk_valid_o), BLK_W'(0));
    check("rst_spec_valid", BLK_W'(spec_valid_o), BLK_W'(0));
    check("rst_frame_cnt", BLK_W'(frame_cnt_o), BLK_W'(0));
    check("rst_busy", BLK_W'(busy_o), BLK_W'(0));
    check("rst_blk_data", blk_data_o, BLK_W'(0));
    rstn = 1'b1;

    // First block, ramp samples
    @(posedge clk); #1;
    enable = 1'b1;
    for (int k = 1; k <= NUM_CH; k++) send({16'(k), 16'(k)});
    @(negedge clk);
    check("blk_latency", BLK_W'(blk_valid_o), BLK_W'(1));
    check("lane7", BLK_W'(blk_data_o[7*DW +: DW]), BLK_W'(32'h0001_0001));
    check("lane0", BLK_W'(blk_data_o[0 +: DW]), BLK_W'(32'h0008_0008));
    enable = 1'b0;
    repeat (PL + 3) @(negedge clk);
    check("t1_spec_cnt", BLK_W'(spec_cnt), BLK_W'(1));
    check("t1_frame_cnt", BLK_W'(frame_cnt_o), BLK_W'(1));

    // 64 samples with valid toggling
    do_reset();
    b0 = blk_seen;
    @(posedge clk); #1;
    enable = 1'b1;
    for (int i = 0; i < 64; i++) begin
      send($urandom);
      @(posedge clk); #1;
    end
    enable = 1'b0;
    repeat (PL + 4) @(negedge clk);
    check("t2_blocks", BLK_W'(blk_seen - b0), BLK_W'(8));
    check("t2_frame_cnt", BLK_W'(frame_cnt_o), BLK_W'(8));

    // Disable in the middle of a block
    do_reset();
    @(posedge clk); #1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) send(32'hA000_0000 + 32'(i));
    enable = 1'b0;
    for (int i = 3; i < NUM_CH; i++) begin
      check("t3_ready_hold", BLK_W'(s_ready_o), BLK_W'(1));
      send(32'hA000_0000 + 32'(i));
    end
    @(negedge clk);
    check("t3_strobe", BLK_W'(blk_valid_o), BLK_W'(1));
    check("t3_ready_drop", BLK_W'(s_ready_o), BLK_W'(0));
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (s_ready_o) seen++;
    end
    check("t3_no_ready", BLK_W'(seen), BLK_W'(0));

    // Flush from IDLE
    do_reset();
    push_zeros();
    pulse_flush();
    @(negedge clk);
    check("t4_pre_strobe", BLK_W'(blk_valid_o), BLK_W'(0));
    for (int i = 0; i < TAPS; i++) begin
      @(negedge clk);
      check("t4_strobe", BLK_W'(blk_valid_o), BLK_W'(1));
      check("t4_ready", BLK_W'(s_ready_o), BLK_W'(0));
    end
    @(negedge clk);
    check("t4_strobe_end", BLK_W'(blk_valid_o), BLK_W'(0));
    g = 0;
    while (busy_o && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("t4_busy_fall", BLK_W'(cyc), BLK_W'(last_spec + 1));
    check("t4_spec_cnt", BLK_W'(spec_cnt), BLK_W'(TAPS));
    check("t4_frame_cnt", BLK_W'(frame_cnt_o), BLK_W'(TAPS));

    // Flush requested mid-block, second request during FLUSH
    do_reset();
    @(posedge clk); #1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) send(32'hB000_0000 + 32'(i));
    pulse_flush();
    enable = 1'b0;
    for (int i = 3; i < NUM_CH; i++) send(32'hB000_0000 + 32'(i));
    push_zeros();
    for (int i = 0; i < TAPS + 1; i++) begin
      @(negedge clk);
      check("t5_strobe", BLK_W'(blk_valid_o), BLK_W'(1));
      if (i == 1) flush = 1'b1;
      if (i == 2) flush = 1'b0;
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (blk_valid_o || s_ready_o) seen++;
    end
    check("t5_quiet", BLK_W'(seen), BLK_W'(0));
    check("t5_spec_cnt", BLK_W'(spec_cnt), BLK_W'(TAPS + 1));
    check("t5_idle", BLK_W'(busy_o), BLK_W'(0));

    // Reset while spectra are in flight
    do_reset();
    push_zeros();
    pulse_flush();
    @(negedge clk);
    repeat (TAPS) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_blk_valid", BLK_W'(blk_valid_o), BLK_W'(0));
    check("t6_spec_valid", BLK_W'(spec_valid_o), BLK_W'(0));
    check("t6_busy", BLK_W'(busy_o), BLK_W'(0));
    check("t6_ready", BLK_W'(s_ready_o), BLK_W'(0));
    exp_q.delete(); spec_q.delete();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (spec_valid_o) seen++;
    end
    check("t6_no_spec", BLK_W'(seen), BLK_W'(0));
    check("t6_frame_cnt", BLK_W'(frame_cnt_o), BLK_W'(0));

    // Frame counter wrap
    do_reset();
    @(posedge clk); #1;
    enable = 1'b1;
    for (int i = 0; i < NUM_CH; i++) send(32'hC000_0000 + 32'(i));
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    force dut.u_lat.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.u_lat.frame_cnt;
    check("t7_preload", BLK_W'(frame_cnt_o), BLK_W'(16'hFFFF));
    repeat (8) @(negedge clk);
    check("t7_wrap", BLK_W'(frame_cnt_o), BLK_W'(16'h0000));
    check("t7_spec_cnt", BLK_W'(spec_cnt), BLK_W'(1));

    check("end_blk_queue", BLK_W'(exp_q.size()), BLK_W'(0));
    check("end_spec_queue", BLK_W'(spec_q.size()), BLK_W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
